// File: rtl/int_sequencer_if.sv
// Data-memory port shared between the pipeline and the interrupt sequencer.
// The sequencer is the master while it owns the port.
interface int_sequencer_if #(
  parameter int D_W = 16
);
  logic           mem_own;
  logic [D_W-1:0] mem_addr;
  logic [D_W-1:0] mem_wdata;
  logic           mem_we;
  logic           mem_re;
  logic [D_W-1:0] mem_rdata;

  modport master (
    output mem_own,
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_own,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/int_sequencer.sv
// Interrupt entry sequencer: drain, push resume PC, fetch vector, load PC.
// Sits beside the PC unit and EX/MEM; owns the data port while active.
module int_sequencer #(
  parameter int             PC_W     = 32,
  parameter int             D_W      = 16,
  parameter logic [D_W-1:0] VEC_ADDR = 16'h0002
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            int_req,
  input  logic            int_en,
  input  logic            stall_safe,
  input  logic [PC_W-1:0] resume_pc,
  input  logic [D_W-1:0]  sp,
  int_sequencer_if.master mem,
  output logic            freeze,
  output logic            flush,
  output logic            sp_dec,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_load_val,
  output logic            int_ack,
  output logic            busy
);

  localparam logic [D_W-1:0] VEC_HI_ADDR =
    VEC_ADDR + 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    VEC_LO,
    VEC_HI,
    LOAD
  } seqState_e;

  seqState_e       state;
  seqState_e       stateNxt;
  logic            reqQ;
  logic            pending;
  logic            reqEdge;
  logic [D_W-1:0]  spLat;
  logic [PC_W-1:0] pcLat;
  logic [D_W-1:0]  vecLo;

  assign reqEdge = int_req & ~reqQ;

  // reqQ resets high so a line held through reset is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      reqQ    <= 1'b1;
      pending <= 1'b0;
      spLat   <= '0;
      pcLat   <= '0;
      vecLo   <= '0;
    end else begin
      state <= stateNxt;
      reqQ  <= int_req;
      if (reqEdge) begin
        pending <= 1'b1;
      end else if (state == LOAD) begin
        pending <= 1'b0;
      end
      if (state == DRAIN && stall_safe) begin
        spLat <= sp;
        pcLat <= resume_pc;
      end
      if (state == VEC_HI) begin
        vecLo <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    stateNxt      = state;
    freeze        = 1'b0;
    flush         = 1'b0;
    sp_dec        = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = '0;
    int_ack       = 1'b0;
    mem.mem_own   = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_we    = 1'b0;
    mem.mem_re    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending && int_en) begin
          stateNxt = DRAIN;
        end
      end
      DRAIN: begin
        freeze = 1'b1;
        if (stall_safe) begin
          stateNxt = PUSH_HI;
        end
      end
      PUSH_HI: begin
        freeze        = 1'b1;
        flush         = 1'b1;
        sp_dec        = 1'b1;
        mem.mem_own   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = spLat;
        mem.mem_wdata = pcLat[PC_W-1:PC_W-D_W];
        stateNxt      = PUSH_LO;
      end
      PUSH_LO: begin
        freeze        = 1'b1;
        sp_dec        = 1'b1;
        mem.mem_own   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = spLat - 1'b1;
        mem.mem_wdata = pcLat[D_W-1:0];
        stateNxt      = VEC_LO;
      end
      VEC_LO: begin
        freeze       = 1'b1;
        mem.mem_own  = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = VEC_ADDR;
        stateNxt     = VEC_HI;
      end
      VEC_HI: begin
        freeze       = 1'b1;
        mem.mem_own  = 1'b1;
        mem.mem_re   = 1'b1;
        mem.mem_addr = VEC_HI_ADDR;
        stateNxt     = LOAD;
      end
      LOAD: begin
        freeze      = 1'b1;
        pc_load     = 1'b1;
        int_ack     = 1'b1;
        pc_load_val = {mem.mem_rdata, vecLo};
        stateNxt    = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer: stack writes and PC loads
// are queued at stimulus time and compared as the DUT produces them.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic        int_en;
  logic        stall_safe;
  logic [31:0] resume_pc;
  logic [15:0] sp;
  logic        freeze;
  logic        flush;
  logic        sp_dec;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        int_ack;
  logic        busy;

  logic [15:0] vLo;
  logic [15:0] vHi;

  int checks = 0;
  int errors = 0;
  int spDecs = 0;
  int acks = 0;
  int flushes = 0;

  logic [31:0] wq[$];
  logic [31:0] pcq[$];

  always #5 clk = ~clk;

  int_sequencer_if bus ();

  int_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .int_req    (int_req),
    .int_en     (int_en),
    .stall_safe (stall_safe),
    .resume_pc  (resume_pc),
    .sp         (sp),
    .mem        (bus),
    .freeze     (freeze),
    .flush      (flush),
    .sp_dec     (sp_dec),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .int_ack    (int_ack),
    .busy       (busy)
  );

  // Vector memory: synchronous read, data valid the cycle after mem_re
  always @(posedge clk) begin
    if (bus.mem_own && bus.mem_re) begin
      if (bus.mem_addr == 16'h0002) bus.mem_rdata <= vLo;
      else if (bus.mem_addr == 16'h0003) bus.mem_rdata <= vHi;
      else bus.mem_rdata <= 16'h5A5A;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      logic [31:0] e;
      if (bus.mem_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = wq.pop_front();
          if ({bus.mem_own, bus.mem_addr, bus.mem_wdata}
              !== {1'b1, e}) begin
            errors++;
            $display("FAIL stack_write got own=%b %h@%h want %h@%h",
                     bus.mem_own, bus.mem_wdata, bus.mem_addr,
                     e[15:0], e[31:16]);
          end
        end
      end
      if (pc_load) begin
        checks++;
        if (pcq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pc_load val=%h", pc_load_val);
        end else begin
          e = pcq.pop_front();
          if (pc_load_val !== e || int_ack !== 1'b1) begin
            errors++;
            $display("FAIL pc_load_val got %h ack=%b want %h ack=1",
                     pc_load_val, int_ack, e);
          end
        end
      end else if (pc_load_val !== 32'h0 || int_ack !== 1'b0) begin
        errors++;
        $display("FAIL idle_pc_val got %h ack=%b want 0",
                 pc_load_val, int_ack);
      end
      if (!bus.mem_own &&
          {bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re}
          !== 34'h0) begin
        errors++;
        $display("FAIL unowned_bus addr=%h wdata=%h we=%b re=%b want 0",
                 bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re);
      end
      spDecs  += int'(sp_dec);
      acks    += int'(int_ack);
      flushes += int'(flush);
    end
  end

  task automatic waitFor(input int which, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if ((which == 0 && busy === 1'b0) ||
          (which == 1 && busy === 1'b1) ||
          (which == 2 && pc_load === 1'b1) ||
          (which == 3 && bus.mem_re === 1'b1)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic expectEntry(input logic [15:0] s,
                             input logic [31:0] pc,
                             input logic [15:0] lo,
                             input logic [15:0] hi);
    logic [15:0] s1;
    s1 = s - 16'd1;
    wq.push_back({s, pc[31:16]});
    wq.push_back({s1, pc[15:0]});
    pcq.push_back({hi, lo});
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (wq.size() != 0 || pcq.size() != 0) begin
      errors++;
      $display("FAIL %s_queues writes_left=%0d loads_left=%0d want 0",
               name, wq.size(), pcq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    int_req = 1'b1;
    int_en = 1'b1;
    stall_safe = 1'b1;
    resume_pc = 32'h0;
    sp = 16'h0;
    vLo = 16'h0;
    vHi = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({freeze, flush, sp_dec, pc_load, pc_load_val, int_ack, busy,
         bus.mem_own, bus.mem_addr, bus.mem_wdata, bus.mem_we,
         bus.mem_re} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b freeze=%b own=%b want 0",
               busy, freeze, bus.mem_own);
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL held_req_after_reset busy=%b want 0", busy);
      end
    end
    int_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    int s0, a0, f0;
    sp = 16'h07FF;
    resume_pc = 32'h0001_0234;
    vLo = 16'h0100;
    vHi = 16'h0000;
    s0 = spDecs; a0 = acks; f0 = flushes;
    expectEntry(16'h07FF, 32'h0001_0234, 16'h0100, 16'h0000);
    int_req = 1'b1;
    waitFor(2, cyc);
    checks++;
    if (cyc != 7) begin
      errors++;
      $display("FAIL basic_latency got %0d want 7", cyc);
    end
    int_req = 1'b0;
    waitFor(0, cyc);
    checks++;
    if (cyc < 0 || spDecs - s0 != 2 || acks - a0 != 1 ||
        flushes - f0 != 1) begin
      errors++;
      $display("FAIL basic_counts sp_dec=%0d ack=%0d flush=%0d want 2 1 1",
               spDecs - s0, acks - a0, flushes - f0);
    end
    checkDrained("basic");
  endtask

  task automatic test_drain_wait();
    int cyc;
    stall_safe = 1'b0;
    sp = 16'h1000;
    resume_pc = 32'h1111_1111;
    vLo = 16'h1234;
    vHi = 16'hABCD;
    expectEntry(16'h1000, 32'hDEAD_BEEF, 16'h1234, 16'hABCD);
    int_req = 1'b1;
    waitFor(1, cyc);
    int_req = 1'b0;
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL drain_start timeout want busy");
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (freeze !== 1'b1 || bus.mem_own !== 1'b0 ||
          flush !== 1'b0 || sp_dec !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold freeze=%b own=%b flush=%b want 1 0 0",
                 freeze, bus.mem_own, flush);
      end
      resume_pc = 32'h1111_0000 + i;
      @(negedge clk);
    end
    stall_safe = 1'b1;
    resume_pc = 32'hDEAD_BEEF;
    @(negedge clk);
    resume_pc = 32'h0BAD_0BAD;
    checks++;
    if (flush !== 1'b1 || bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL drain_exit flush=%b we=%b want 1 1",
               flush, bus.mem_we);
    end
    waitFor(0, cyc);
    checkDrained("drain");
  endtask

  task automatic test_masking();
    int cyc;
    int a0;
    logic sawBusy;
    int_en = 1'b0;
    sp = 16'h0800;
    resume_pc = 32'h0000_4444;
    vLo = 16'h2222;
    vHi = 16'h0001;
    a0 = acks;
    expectEntry(16'h0800, 32'h0000_4444, 16'h2222, 16'h0001);
    expectEntry(16'h0800, 32'h0000_4444, 16'h2222, 16'h0001);
    int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    sawBusy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy = 1'b1;
    end
    checks++;
    if (sawBusy) begin
      errors++;
      $display("FAIL masked_busy got 1 want 0");
    end
    int_en = 1'b1;
    waitFor(1, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL unmask_start got %0d want 1", cyc);
    end
    int_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_abort busy=%b want 1", busy);
    end
    int_en = 1'b1;
    waitFor(2, cyc);
    int_req = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL after_load busy=%b pc_load=%b want 0 0",
               busy, pc_load);
    end
    @(negedge clk);
    int_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || freeze !== 1'b1) begin
      errors++;
      $display("FAIL requeue_start busy=%b freeze=%b want 1 1",
               busy, freeze);
    end
    waitFor(0, cyc);
    checks++;
    if (acks - a0 != 2) begin
      errors++;
      $display("FAIL masking_acks got %0d want 2", acks - a0);
    end
    checkDrained("masking");
  endtask

  task automatic test_sp_wrap();
    int cyc;
    int s0;
    sp = 16'h0000;
    resume_pc = 32'hCAFE_F00D;
    vLo = 16'h0040;
    vHi = 16'h8000;
    s0 = spDecs;
    wq.push_back({16'h0000, 16'hCAFE});
    wq.push_back({16'hFFFF, 16'hF00D});
    pcq.push_back(32'h8000_0040);
    int_req = 1'b1;
    waitFor(2, cyc);
    int_req = 1'b0;
    waitFor(0, cyc);
    checks++;
    if (spDecs - s0 != 2) begin
      errors++;
      $display("FAIL wrap_sp_dec got %0d want 2", spDecs - s0);
    end
    checkDrained("wrap");
  endtask

  task automatic test_async_reset();
    int cyc;
    logic sawBusy;
    sp = 16'h0500;
    resume_pc = 32'h0003_0005;
    vLo = 16'h0777;
    vHi = 16'h0009;
    wq.push_back({16'h0500, 16'h0003});
    wq.push_back({16'h04FF, 16'h0005});
    int_req = 1'b1;
    waitFor(3, cyc);
    checks++;
    if (cyc < 0 || bus.mem_addr !== 16'h0002) begin
      errors++;
      $display("FAIL vec_lo_reach cyc=%0d addr=%h want addr 0002",
               cyc, bus.mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({freeze, flush, sp_dec, pc_load, pc_load_val, int_ack, busy,
         bus.mem_own, bus.mem_addr, bus.mem_wdata, bus.mem_we,
         bus.mem_re} !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b own=%b re=%b want 0",
               busy, bus.mem_own, bus.mem_re);
    end
    #1 reset = 1'b1;
    sawBusy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy = 1'b1;
    end
    checks++;
    if (sawBusy) begin
      errors++;
      $display("FAIL held_after_abort busy=1 want 0");
    end
    checkDrained("abort");
    int_req = 1'b0;
    @(negedge clk);
    expectEntry(16'h0500, 32'h0003_0005, 16'h0777, 16'h0009);
    int_req = 1'b1;
    waitFor(2, cyc);
    int_req = 1'b0;
    checks++;
    if (cyc != 7) begin
      errors++;
      $display("FAIL retrigger_latency got %0d want 7", cyc);
    end
    waitFor(0, cyc);
    checkDrained("retrigger");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain_wait();
    test_masking();
    test_sp_wrap();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
